// File: rtl/bus_share_pkg.sv
// Shared definitions for the bus_share_arbiter slice: widths, the requester
// index type and the output-register state enum.
package bus_share_pkg;

  localparam int DATA_W = 16;
  localparam int N_REQ  = 4;

  typedef logic [1:0] req_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/bus_share_arbiter_rr_pick4.sv
// rr_pick4: combinational round-robin pick over four request lines.
// The search starts at last+1 and wraps, so the most recent winner has
// the lowest priority on the next decision.
module rr_pick4
  import bus_share_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] winner,
  output logic       any
);

  // Scan upward from last+1 and keep the first set request bit.
  always_comb begin
    req_idx_t idx;
    logic     found;
    winner = '0;
    any    = |req;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = req_idx_t'(last + req_idx_t'(i));
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_share_arbiter.sv
// bus_share_arbiter: shares one registered 16-bit output bus between four
// requesters with round-robin arbitration and a valid/ready handshake.
// Optional build macro BUS_SHARE_ARB_PRIO0_EN gives requester 0 absolute
// priority; the round-robin pointer still tracks every grant.
module bus_share_arbiter
  import bus_share_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] a2,
  input  logic [DATA_W-1:0] a3,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  ack,
  output logic [DATA_W-1:0] d,
  output logic              d_valid,
  input  logic              d_ready,
  output logic [1:0]        s
);

  state_t      state;
  req_idx_t    last;
  req_idx_t    rr_winner;
  logic        rr_any;
  req_idx_t    pick;
  logic        free;
  logic        grant;
  logic [DATA_W-1:0] mux_word;

  rr_pick4 u_pick (
    .req    (req),
    .last   (last),
    .winner (rr_winner),
    .any    (rr_any)
  );

  // Final winner selection; the priority build lets a0 pre-empt the pointer.
  always_comb begin
`ifdef BUS_SHARE_ARB_PRIO0_EN
    pick = req[0] ? req_idx_t'(0) : rr_winner;
`else
    pick = rr_winner;
`endif
  end

  // The output register may take a new word when empty or being drained now;
  // reset gating keeps ack quiet while rst_n is low.
  always_comb begin
    free  = (state == IDLE) || d_ready;
    grant = free && rr_any && rst_n;
  end

  // One-hot acknowledge for the requester captured on the coming edge.
  always_comb begin
    ack = '0;
    if (grant) ack[pick] = 1'b1;
  end

  // 4:1 data mux steered by the next winner.
  always_comb begin
    case (pick)
      2'd0:    mux_word = a0;
      2'd1:    mux_word = a1;
      2'd2:    mux_word = a2;
      default: mux_word = a3;
    endcase
  end

  // Output register FSM: load on a free grant, empty on a free idle cycle,
  // otherwise hold so an unconsumed word is never overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      d       <= '0;
      s       <= '0;
      d_valid <= 1'b0;
      last    <= req_idx_t'(3);
    end else if (free) begin
      if (rr_any) begin
        state   <= HOLD;
        d       <= mux_word;
        s       <= pick;
        last    <= pick;
        d_valid <= 1'b1;
      end else begin
        state   <= IDLE;
        d_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/bus_share_arbiter.md
# bus_share_arbiter

Round-robin arbiter that shares one registered 16-bit output bus between four 16-bit requesters (a0..a3). Internally it drives the select of the existing 16-bit 4:1 multiplexer datapath, captures the winning word and presents it downstream with a valid/ready handshake. It sits between four producer blocks and a single consumer; throughput is one word per clock when the consumer is always ready.

## Interface
- No parameters; data width 16 and requester count 4 are fixed.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- a0, a1, a2, a3  in  16 each  requester data; must be stable while the matching req bit is high
- req  in  4  level request; bit i belongs to ai
- ack  out  4  one-cycle pulse; bit i high means ai was captured on this edge
- d  out  16  registered output word
- d_valid  out  1  d holds an unconsumed word
- d_ready  in  1  consumer accepts d when d_valid & d_ready
- s  out  2  index of the requester whose word is in d

## Operation
- States: IDLE (d_valid=0), HOLD (d_valid=1).
- Arbitration is "free" when the state is IDLE, or when the state is HOLD and d_ready=1 in the same cycle.
- When arbitration is free and req≠0: the winner is the first set req bit searching upward from last+1 mod 4. On the edge, d<=a[winner], s<=winner, last<=winner, d_valid<=1, and ack[winner] is high for that cycle (combinational from the same decision, so it is visible before the edge). Next state is HOLD.
- When arbitration is free and req=0: d_valid<=0. d, s and last hold their values. Next state is IDLE.
- HOLD with d_ready=0: all registers hold, ack=0. A word is never dropped or overwritten.
- A requester that sees ack[i] presents its next word or drops req[i] on the following cycle. If req[i] stays high, that is a new request.
- Only one ack bit is ever high in a cycle. Any other requester is served within 3 further grants (fairness bound).
- Reset values: d=0, s=0, d_valid=0, ack=0, last=3 (so a0 has first priority), state IDLE.
- Reset asserted mid-transfer discards the held word immediately and asynchronously. No ack is issued while rst_n=0.

## Timing
- Request to valid latency is 1 cycle: req sampled at edge N gives d_valid=1 after edge N.
- Back-to-back transfers: with d_ready held at 1 and req≠0, a new word is loaded every cycle with no bubble.
- ack is combinational from req, state, last and d_ready. d, s and d_valid are pure register outputs.
- A req bit that drops in the same cycle it would have won is simply not granted. No ack is issued.

## Configuration
- Macro BUS_SHARE_ARB_PRIO0_EN.
- Defined:
  - req[0] wins whenever it is set, regardless of the round-robin pointer.
  - The pointer is still updated on every grant.
  - Only the fairness bound for a1..a3 is relaxed.
- Undefined: pure round-robin as described above. This is the default.

## Structure
- Shared package bus_share_pkg holds:
  - localparam DATA_W=16 and localparam N_REQ=4
  - a typedef for the 2-bit requester index
  - the IDLE/HOLD state enum
- One sub-module, rr_pick4:
  - Inputs: req[3:0], last[1:0].
  - Outputs: winner[1:0], any.
  - Purely combinational.
- The data path reuses the team's 16-bit 4:1 mux, with s (or the next winner) driving its select.

## Test plan
- Reset, then req=4'b0001, a0=16'h1234, d_ready=1 → ack=4'b0001 for one cycle; next cycle d=16'h1234, s=0, d_valid=1.
- req=4'b1111 held, d_ready=1, all data distinct → s sequence 0,1,2,3,0 on consecutive cycles; exactly one ack bit per cycle.
- Word loaded from a2, d_ready=0 for 5 cycles while req=4'b1011 → d, s=2 and d_valid unchanged, ack=0; when d_ready rises, the next grant goes to a3.
- req toggles 4'b0000 → d_valid falls one cycle after the last accept; d keeps its final value.
- rst_n pulsed low while d_valid=1 → d_valid=0, d=0, s=0 asynchronously; after release with req=4'b1000 → the first grant is a3.
- With BUS_SHARE_ARB_PRIO0_EN and req=4'b0011 held → every grant is a0; without the macro, grants alternate 0,1.
